// File: rtl/ring_counter_param.sv
// Parametrised ring / Johnson sequence counter with bidirectional stepping,
// parallel load, decoded step index, wrap pulse and illegal-state recovery.
module ring_counter_param #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MODE  = 0,
    localparam int unsigned PERIOD = (MODE == 0) ? WIDTH : 2 * WIDTH,
    localparam int unsigned IDX_W  = $clog2(PERIOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [IDX_W-1:0] idx,
    output logic             legal,
    output logic             wrap,
    output logic             fix
);

    localparam logic [WIDTH-1:0] RST_VAL = (MODE == 0) ? WIDTH'(1) : '0;

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic             fix_q, fix_d;
    logic [IDX_W-1:0] idx_c;
    logic             legal_c;
    logic             wrap_step_c;
    int unsigned      ones;
    int unsigned      pos;
    int unsigned      raw_idx;

    // Contiguous ones from the LSB (includes all-zero and all-one words).
    function automatic logic is_thermo(input logic [WIDTH-1:0] v);
        return (v & (v + WIDTH'(1))) == '0;
    endfunction

    // Decode legality and step index from the current state.
    always_comb begin
        ones    = 0;
        pos     = 0;
        raw_idx = 0;
        legal_c = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (out_q[i]) begin
                ones = ones + 1;
                pos  = i;
            end
        end
        if (MODE == 0) begin
            legal_c = (ones == 1);
            raw_idx = pos;
        end else begin
            legal_c = is_thermo(out_q) || is_thermo(~out_q);
            raw_idx = out_q[WIDTH-1] ? (WIDTH + (WIDTH - ones)) : ones;
        end
        idx_c       = legal_c ? IDX_W'(raw_idx) : '0;
        wrap_step_c = dir ? (idx_c == '0) : (idx_c == IDX_W'(PERIOD - 1));
    end

    // Next state: load beats stepping; stepping from an illegal code recovers.
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        fix_d  = 1'b0;
        if (load) begin
            out_d = load_val;
        end else if (en) begin
            if (!legal_c) begin
                out_d = RST_VAL;
                fix_d = 1'b1;
            end else begin
                wrap_d = wrap_step_c;
                if (MODE == 0) begin
                    out_d = dir ? {out_q[0], out_q[WIDTH-1:1]}
                                : {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                end else begin
                    out_d = dir ? {~out_q[0], out_q[WIDTH-1:1]}
                                : {out_q[WIDTH-2:0], ~out_q[WIDTH-1]};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q  <= RST_VAL;
            wrap_q <= 1'b0;
            fix_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
            fix_q  <= fix_d;
        end
    end

    assign out   = out_q;
    assign idx   = idx_c;
    assign legal = legal_c;
    assign wrap  = wrap_q;
    assign fix   = fix_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// Bench for ring_counter_param: ring W=4, Johnson W=4 and Johnson W=5 side by
// side, directed sequences plus random stimulus against a step-index model.
module tb_ring_counter_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val4 = '0;
    logic [4:0] load_val5 = '0;

    logic [3:0] r4_out;  logic [1:0] r4_idx;  logic r4_legal, r4_wrap, r4_fix;
    logic [3:0] j4_out;  logic [2:0] j4_idx;  logic j4_legal, j4_wrap, j4_fix;
    logic [4:0] j5_out;  logic [3:0] j5_idx;  logic j5_legal, j5_wrap, j5_fix;

    ring_counter_param #(.WIDTH(4), .MODE(0)) u_r4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val4),
        .out(r4_out), .idx(r4_idx), .legal(r4_legal), .wrap(r4_wrap), .fix(r4_fix));
    ring_counter_param #(.WIDTH(4), .MODE(1)) u_j4 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val4),
        .out(j4_out), .idx(j4_idx), .legal(j4_legal), .wrap(j4_wrap), .fix(j4_fix));
    ring_counter_param #(.WIDTH(5), .MODE(1)) u_j5 (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val5),
        .out(j5_out), .idx(j5_idx), .legal(j5_legal), .wrap(j5_wrap), .fix(j5_fix));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-instance view for the model comparisons.
    logic [7:0] d_out [3];
    logic [7:0] d_idx [3];
    logic       d_legal [3];
    logic       d_wrap [3];
    logic       d_fix [3];
    assign d_out[0] = 8'(r4_out);  assign d_idx[0] = 8'(r4_idx);
    assign d_out[1] = 8'(j4_out);  assign d_idx[1] = 8'(j4_idx);
    assign d_out[2] = 8'(j5_out);  assign d_idx[2] = 8'(j5_idx);
    assign d_legal[0] = r4_legal;  assign d_wrap[0] = r4_wrap;  assign d_fix[0] = r4_fix;
    assign d_legal[1] = j4_legal;  assign d_wrap[1] = j4_wrap;  assign d_fix[1] = j4_fix;
    assign d_legal[2] = j5_legal;  assign d_wrap[2] = j5_wrap;  assign d_fix[2] = j5_fix;

    int k_w [3]    = '{4, 4, 5};
    int k_mode [3] = '{0, 1, 1};

    // Model state: a step position in the sequence, or a raw illegal word.
    int         m_p [3];
    bit         m_ill [3];
    logic [7:0] m_raw [3];
    bit         m_wrap [3];
    bit         m_fix [3];

    function automatic int period_of(int k);
        return (k_mode[k] == 0) ? k_w[k] : 2 * k_w[k];
    endfunction

    // Sequence code at position p.
    function automatic logic [7:0] code_of(int k, int p);
        int w;
        logic [7:0] full;
        w = k_w[k];
        full = 8'((1 << w) - 1);
        if (k_mode[k] == 0) return 8'(1 << p);
        if (p <= w) return 8'((1 << p) - 1);
        return full & ~8'((1 << (p - w)) - 1);
    endfunction

    function automatic int find_pos(int k, logic [7:0] v);
        for (int p = 0; p < period_of(k); p++)
            if (code_of(k, p) == v) return p;
        return -1;
    endfunction

    function automatic logic [7:0] exp_out(int k);
        return m_ill[k] ? m_raw[k] : code_of(k, m_p[k]);
    endfunction

    function automatic logic [7:0] exp_idx(int k);
        return m_ill[k] ? 8'd0 : 8'(m_p[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_p[k] = 0; m_ill[k] = 1'b0; m_raw[k] = '0;
            m_wrap[k] = 1'b0; m_fix[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] v;
        int f;
        if (rst) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            m_wrap[k] = 1'b0;
            m_fix[k]  = 1'b0;
            if (load) begin
                v = (k == 2) ? 8'(load_val5) : 8'(load_val4);
                f = find_pos(k, v);
                m_ill[k] = (f < 0);
                m_raw[k] = v;
                m_p[k]   = (f < 0) ? 0 : f;
            end else if (en) begin
                if (m_ill[k]) begin
                    m_ill[k] = 1'b0; m_p[k] = 0; m_fix[k] = 1'b1;
                end else if (dir) begin
                    m_wrap[k] = (m_p[k] == 0);
                    m_p[k] = (m_p[k] + period_of(k) - 1) % period_of(k);
                end else begin
                    m_wrap[k] = (m_p[k] == period_of(k) - 1);
                    m_p[k] = (m_p[k] + 1) % period_of(k);
                end
            end
        end
    endtask

    // Advance one edge; inputs are sampled by the model just before it.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0; dir = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (r4_out !== 4'b0001 || r4_idx !== 2'd0 || r4_legal !== 1'b1 || r4_wrap !== 1'b0 || r4_fix !== 1'b0) begin
            $display("FAIL reset_r4: out=%b idx=%0d legal=%b wrap=%b fix=%b, required 0001/0/1/0/0",
                     r4_out, r4_idx, r4_legal, r4_wrap, r4_fix);
        end else n_pass++;
        n_checks++;
        if (j4_out !== 4'b0000 || j4_idx !== 3'd0 || j4_legal !== 1'b1 || j5_out !== 5'b00000 || j5_legal !== 1'b1) begin
            $display("FAIL reset_johnson: j4=%b idx=%0d legal=%b j5=%b legal=%b, required 0000/0/1 00000/1",
                     j4_out, j4_idx, j4_legal, j5_out, j5_legal);
        end else n_pass++;
    endtask

    task automatic test_ring_up();
        logic [3:0] exp_seq [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        logic [1:0] exp_i   [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++;
            if (r4_out !== exp_seq[i] || r4_idx !== exp_i[i] || r4_wrap !== (i == 3)) begin
                $display("FAIL ring_up step %0d: out=%b idx=%0d wrap=%b, required %b/%0d/%b",
                         i, r4_out, r4_idx, r4_wrap, exp_seq[i], exp_i[i], (i == 3));
            end else n_pass++;
        end
        // Async reset between edges.
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (r4_out !== 4'b0001 || j4_out !== 4'b0000 || r4_wrap !== 1'b0) begin
            $display("FAIL async_reset: r4=%b j4=%b wrap=%b, required 0001 0000 0",
                     r4_out, j4_out, r4_wrap);
        end else n_pass++;
        en = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_down();
        do_reset();
        en = 1'b1; dir = 1'b1;
        step();
        n_checks++;
        if (r4_out !== 4'b1000 || r4_idx !== 2'd3 || r4_wrap !== 1'b1) begin
            $display("FAIL ring_down_1: out=%b idx=%0d wrap=%b, required 1000/3/1", r4_out, r4_idx, r4_wrap);
        end else n_pass++;
        n_checks++;
        if (j5_out !== 5'b10000 || j5_idx !== 4'd9 || j5_wrap !== 1'b1) begin
            $display("FAIL johnson5_down_1: out=%b idx=%0d wrap=%b, required 10000/9/1", j5_out, j5_idx, j5_wrap);
        end else n_pass++;
        step();
        n_checks++;
        if (r4_out !== 4'b0100 || r4_wrap !== 1'b0) begin
            $display("FAIL ring_down_2: out=%b wrap=%b, required 0100/0", r4_out, r4_wrap);
        end else n_pass++;
        n_checks++;
        if (j5_out !== 5'b11000 || j5_idx !== 4'd8 || j5_wrap !== 1'b0) begin
            $display("FAIL johnson5_down_2: out=%b idx=%0d wrap=%b, required 11000/8/0", j5_out, j5_idx, j5_wrap);
        end else n_pass++;
        en = 1'b0; dir = 1'b0;
    endtask

    task automatic test_johnson_up();
        logic [3:0] exp_seq [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                    4'b1110, 4'b1100, 4'b1000, 4'b0000};
        do_reset();
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (j4_out !== exp_seq[i] || j4_idx !== 3'((i + 1) % 8) || j4_wrap !== (i == 7)) begin
                $display("FAIL johnson_up step %0d: out=%b idx=%0d wrap=%b, required %b/%0d/%b",
                         i, j4_out, j4_idx, j4_wrap, exp_seq[i], (i + 1) % 8, (i == 7));
            end else n_pass++;
        end
        en = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        load = 1'b1; load_val4 = 4'b0110;
        step();
        load = 1'b0;
        n_checks++;
        if (r4_out !== 4'b0110 || r4_legal !== 1'b0 || r4_idx !== 2'd0) begin
            $display("FAIL illegal_load: out=%b legal=%b idx=%0d, required 0110/0/0", r4_out, r4_legal, r4_idx);
        end else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (r4_out !== 4'b0110 || r4_fix !== 1'b0) begin
                $display("FAIL illegal_hold %0d: out=%b fix=%b, required 0110/0", i, r4_out, r4_fix);
            end else n_pass++;
        end
        en = 1'b1;
        step();
        n_checks++;
        if (r4_out !== 4'b0001 || r4_fix !== 1'b1 || r4_wrap !== 1'b0) begin
            $display("FAIL illegal_fix: out=%b fix=%b wrap=%b, required 0001/1/0", r4_out, r4_fix, r4_wrap);
        end else n_pass++;
        step();
        n_checks++;
        if (r4_out !== 4'b0010 || r4_fix !== 1'b0) begin
            $display("FAIL illegal_after: out=%b fix=%b, required 0010/0", r4_out, r4_fix);
        end else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_load_priority();
        do_reset();
        load = 1'b1; en = 1'b1; load_val4 = 4'b0100;
        step();
        n_checks++;
        if (r4_out !== 4'b0100 || r4_wrap !== 1'b0) begin
            $display("FAIL load_priority: out=%b wrap=%b, required 0100/0", r4_out, r4_wrap);
        end else n_pass++;
        load = 1'b0;
        step();
        n_checks++;
        if (r4_out !== 4'b1000) begin
            $display("FAIL load_then_step: out=%b, required 1000", r4_out);
        end else n_pass++;
        en = 1'b0;
    endtask

    task automatic test_random();
        int errs;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            load      = ($urandom_range(0, 9) == 0);
            en        = ($urandom_range(0, 3) != 0);
            dir       = ($urandom_range(0, 3) == 0) ? ~dir : dir;
            load_val4 = 4'($urandom);
            load_val5 = 5'($urandom);
            if ($urandom_range(0, 99) == 0) rst = 1'b1;
            step();
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
                errs = 0;
                if (d_out[k] !== exp_out(k)) errs++;
                if (d_idx[k] !== exp_idx(k)) errs++;
                if (d_legal[k] !== !m_ill[k]) errs++;
                if (d_wrap[k] !== m_wrap[k]) errs++;
                if (d_fix[k] !== m_fix[k]) errs++;
                if (d_wrap[k] === 1'b1 && d_fix[k] === 1'b1) errs++;
                n_checks++;
                if (errs != 0) begin
                    $display("FAIL random cyc %0d inst %0d: out=%h idx=%0d legal=%b wrap=%b fix=%b, required %h/%0d/%b/%b/%b",
                             c, k, d_out[k], d_idx[k], d_legal[k], d_wrap[k], d_fix[k],
                             exp_out(k), exp_idx(k), !m_ill[k], m_wrap[k], m_fix[k]);
                end else n_pass++;
            end
        end
        load = 1'b0; en = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ring_up();
        test_down();
        test_johnson_up();
        test_illegal();
        test_load_priority();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ring_counter_param.md
# ring_counter_param

Parametrised shift-register sequence counter. It generates one-hot ring or Johnson (twisted-ring) codes of configurable width, with bidirectional stepping, parallel load, a decoded step index, a wrap pulse, and self-correction from illegal states. It is the general-purpose successor to the fixed 4-bit ring counter and is used for digit/phase sequencing in the lab designs.

## Interface
- WIDTH, 4, register width; legal range ≥ 2.
- MODE, 0, 0 = ring (one-hot), 1 = Johnson.
- PERIOD (localparam), WIDTH if MODE=0 else 2*WIDTH, sequence length.
- IDX_W (localparam), $clog2(PERIOD), width of idx.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance one step per cycle while high.
- dir  in  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
- load  in  1  parallel load of load_val; priority over en.
- load_val  in  WIDTH  value to load, written unchecked.
- out  out  WIDTH  counter state (register).
- idx  out  IDX_W  step index decoded from out (combinational).
- legal  out  1  out is a legal code for MODE (combinational).
- wrap  out  1  registered one-cycle pulse when a step crosses the period boundary.
- fix  out  1  registered one-cycle pulse when an illegal state was corrected.

## Operation
- Reset state: ring = 0…01, Johnson = 0…00. While rst is high: out = reset state, wrap = 0, fix = 0, idx = 0, legal = 1.
- Priority each edge: rst > load > en > hold.
- load=1: out ← load_val; wrap ← 0; fix ← 0. An illegal load_val is accepted as-is.
- en=1, out legal:
  - Ring up: out ← {out[W-2:0], out[W-1]}.
  - Ring down: out ← {out[0], out[W-1:1]}.
  - Johnson up: out ← {out[W-2:0], ~out[W-1]}.
  - Johnson down: out ← {~out[0], out[W-1:1]}.
- en=1, out illegal: out ← reset state; fix ← 1; wrap ← 0. The direction is ignored.
- en=0, load=0: out holds, including an illegal state; wrap ← 0; fix ← 0.
- Legality:
  - Ring: exactly one bit set.
  - Johnson: out = 2^k−1 for some 0≤k≤W, or ~out = 2^k−1 for some 1≤k≤W−1 (contiguous ones from LSB, or contiguous zeros from LSB).
- idx:
  - Ring: bit position of the set bit.
  - Johnson: if out[W-1]=0, idx = popcount(out); else idx = W + number of zero bits.
  - Illegal out: idx = 0.
- wrap ← 1 on a legal step where:
  - up and the old idx = PERIOD−1 (new idx = 0), or
  - down and the old idx = 0 (new idx = PERIOD−1).

## Timing
- One step per enabled edge; out, wrap and fix update on the same edge.
- idx and legal follow out combinationally with zero-cycle latency.
- rst asserts asynchronously: out changes without waiting for clk. Deassertion is sampled at the next rising edge.
- Reset mid-sequence discards the in-flight state. No wrap or fix pulse is generated by reset.
- Toggling dir between consecutive enabled cycles takes effect immediately; no bubble.
- wrap and fix are never both 1 in the same cycle.
- Continuous en=1 gives a wrap every PERIOD cycles.

## Test plan
- Ring up, W=4, reset then en=1 for 6 cycles:
  - Required: out = 0010, 0100, 1000, 0001 (wrap=1, idx=0), 0010, 0100.
  - Then raise rst between edges: out = 0001 immediately.
- Ring down, W=4, from reset with dir=1, en=1 for 1 cycle:
  - Required: out = 1000, idx = 3, wrap = 1.
  - Next step: out = 0100, wrap = 0.
- Johnson up, W=4, en=1 for 8 cycles from 0000:
  - Required: 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; idx = 1…7 then 0; wrap = 1 only on the 8th step.
- Illegal recovery, ring W=4:
  - Load 0110: legal = 0, idx = 0.
  - en=0 for 2 cycles: out holds 0110.
  - en=1: out = 0001, fix = 1, wrap = 0.
  - Next cycle: out = 0010, fix = 0.
- Load priority, ring W=4: load=1, en=1, load_val = 0100.
  - Required: out = 0100.
  - Next edge (load=0, en=1): out = 1000.
- Johnson down, W=5, from reset with dir=1, en=1:
  - Required: out = 10000, idx = 9, wrap = 1.
  - Next step: out = 11000, idx = 8.
